step_controller: RTL and testbench

- Clean execution-step source for the board-level RISCV top. Feeds the core's advance/enable input, replacing the raw 2-flop button edge detector.
- Synchronizes and counter-debounces the active-low step pushbutton.
- Emits exactly one single-cycle step pulse per press, or periodic pulses in free-run mode selected by a switch.
- Keeps a wrapping count of issued steps for debug display.

---
 rtl/step_controller.sv | 130 +++++++++++++
 tb/tb_step_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_controller.sv
// Debounced step button and free-run pulse source that drives the core's
// single-cycle advance strobe, with a wrapping count of issued steps.
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 25000000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_n,
  input  logic             run_sw,
  output logic             step_pulse,
  output logic             btn_level,
  output logic             run_active,
  output logic [CNT_W-1:0] step_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RT_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  db_state_e        state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RT_W-1:0]  rate_q, rate_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             key_meta_q, key_meta_d;
  logic             key_s_q, key_s_d;
  logic             run_meta_q, run_meta_d;
  logic             run_act_q, run_act_d;
  logic             pulse_q, pulse_d;
  logic             press_evt;
  logic             run_tc;

  always_comb begin
    key_meta_d = ~key_n;
    key_s_d    = key_meta_q;
    run_meta_d = run_sw;
    run_act_d  = run_meta_q;
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    press_evt  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (key_s_q) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s_q) begin
          state_d  = RELEASED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = PRESSED;
          db_cnt_d  = '0;
          press_evt = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_s_q) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_s_q) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = RELEASED;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = RELEASED;
        db_cnt_d = '0;
      end
    endcase

    // Rate counter idles at zero so each run starts a full period
    run_tc = run_act_q && (rate_q == RT_LAST);
    if (!run_act_q || run_tc) rate_d = '0;
    else                      rate_d = rate_q + 1'b1;

    pulse_d = run_tc | (press_evt & ~run_act_q);
    count_d = pulse_q ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
      run_meta_q <= 1'b0;
      run_act_q  <= 1'b0;
      state_q    <= RELEASED;
      db_cnt_q   <= '0;
      rate_q     <= '0;
      pulse_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      key_meta_q <= key_meta_d;
      key_s_q    <= key_s_d;
      run_meta_q <= run_meta_d;
      run_act_q  <= run_act_d;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      rate_q     <= rate_d;
      pulse_q    <= pulse_d;
      count_q    <= count_d;
    end
  end

  assign step_pulse = pulse_q;
  assign btn_level  = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign run_active = run_act_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with small debounce/run parameters;
// expectations are hand-derived cycle counts.
module tb_step_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic       run_sw;
  logic       step_pulse;
  logic       btn_level;
  logic       run_active;
  logic [3:0] step_count;

  int checks = 0;
  int errors = 0;

  step_controller #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .run_sw(run_sw),
    .step_pulse(step_pulse),
    .btn_level(btn_level),
    .run_active(run_active),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    key_n  = 1'b1;
    run_sw = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int np;
    int at;
    int nb;
    int exp_cnt;
    int pulse_at[8];
    logic pat[8];

    // Reset with inputs active
    reset  = 1'b1;
    key_n  = 1'b0;
    run_sw = 1'b1;
    tick();
    tick();
    chk("rst_pulse", step_pulse, 0);
    chk("rst_btn", btn_level, 0);
    chk("rst_run", run_active, 0);
    chk("rst_cnt", step_count, 0);
    reset  = 1'b0;
    key_n  = 1'b1;
    run_sw = 1'b0;
    repeat (6) tick();
    chk("idle_btn", btn_level, 0);
    chk("idle_cnt", step_count, 0);

    // Clean press: visible on the 7th edge
    key_n = 1'b0;
    repeat (6) tick();
    chk("press_early_btn", btn_level, 0);
    chk("press_early_pulse", step_pulse, 0);
    tick();
    chk("press_btn", btn_level, 1);
    chk("press_pulse", step_pulse, 1);
    chk("press_cnt_pre", step_count, 0);
    tick();
    chk("press_pulse_off", step_pulse, 0);
    chk("press_cnt", step_count, 1);
    np = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      np += int'(step_pulse);
    end
    chk("hold_pulses", np, 0);
    chk("hold_btn", btn_level, 1);
    key_n = 1'b1;
    repeat (5) tick();
    chk("release_wait_btn", btn_level, 1);
    tick();
    tick();
    chk("release_btn", btn_level, 0);
    chk("release_cnt", step_count, 1);

    // Bounce then steady press
    do_reset();
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    np = 0;
    for (int i = 0; i < 8; i++) begin
      key_n = pat[i];
      tick();
      np += int'(step_pulse);
    end
    chk("bounce_btn", btn_level, 0);
    key_n = 1'b0;
    at = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (step_pulse) begin
        np++;
        at = t;
      end
    end
    chk("bounce_npulse", np, 1);
    chk("bounce_at", at, 7);
    chk("bounce_cnt", step_count, 1);
    key_n = 1'b1;
    repeat (8) tick();

    // Glitches of 3 and 4 cycles are rejected
    do_reset();
    np = 0;
    nb = 0;
    for (int g = 3; g <= 4; g++) begin
      key_n = 1'b0;
      for (int t = 0; t < g; t++) begin
        tick();
        np += int'(step_pulse);
        nb += int'(btn_level);
      end
      key_n = 1'b1;
      for (int t = 0; t < 10; t++) begin
        tick();
        np += int'(step_pulse);
        nb += int'(btn_level);
      end
    end
    chk("glitch_pulses", np, 0);
    chk("glitch_btn", nb, 0);
    key_n = 1'b0;
    at = -1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (step_pulse && at < 0) at = t;
    end
    chk("glitch_then_press_at", at, 7);
    key_n = 1'b1;
    repeat (8) tick();

    // Free-run with a press in the middle
    do_reset();
    run_sw = 1'b1;
    np = 0;
    for (int t = 1; t <= 36; t++) begin
      tick();
      if (t == 1) chk("run_sync_lat0", run_active, 0);
      if (t == 2) chk("run_sync_lat1", run_active, 1);
      if (t == 25) chk("run_press_btn", btn_level, 1);
      if (step_pulse) begin
        if (np < 8) pulse_at[np] = t;
        np++;
      end
      if (t == 12) key_n = 1'b0;
      if (t == 30) key_n = 1'b1;
    end
    chk("run_npulse", np, 4);
    chk("run_p0", pulse_at[0], 10);
    chk("run_p1", pulse_at[1], 18);
    chk("run_p2", pulse_at[2], 26);
    chk("run_p3", pulse_at[3], 34);
    run_sw = 1'b0;
    np = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      np += int'(step_pulse);
    end
    chk("stop_pulses", np, 0);
    chk("stop_run", run_active, 0);
    chk("stop_btn", btn_level, 0);
    chk("stop_cnt", step_count, 4);
    run_sw = 1'b1;
    at = -1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (step_pulse && at < 0) at = t;
    end
    chk("rerun_first_at", at, 10);
    chk("rerun_cnt", step_count, 5);
    run_sw = 1'b0;
    repeat (4) tick();

    // Reset mid-debounce abandons progress
    do_reset();
    key_n = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("midrst_pulse", step_pulse, 0);
    chk("midrst_btn", btn_level, 0);
    reset = 1'b0;
    at = -1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (step_pulse && at < 0) at = t;
    end
    chk("midrst_press_at", at, 7);
    key_n = 1'b1;
    repeat (8) tick();

    // 17 free-run steps wrap the 4-bit count
    do_reset();
    run_sw = 1'b1;
    np = 0;
    exp_cnt = 0;
    for (int t = 1; t <= 139; t++) begin
      tick();
      if (step_pulse) begin
        chk("wrap_seq", step_count, exp_cnt);
        exp_cnt = (exp_cnt + 1) % 16;
        np++;
      end
    end
    chk("wrap_npulse", np, 17);
    chk("wrap_final", step_count, 1);
    run_sw = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
